// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the cores, the data-memory arbiter and the single-port data RAM.
// The slave modport is the arbiter's view; the master modport is the cores/RAM side.
interface dmem_arbiter_if #(
    parameter int NCORES = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    c_rd;
    logic [NCORES-1:0]    c_wr;
    logic [NCORES*AW-1:0] c_addr;
    logic [NCORES*DW-1:0] c_wdata;
    logic [DW-1:0]        c_rdata;
    logic [NCORES-1:0]    c_dacq;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_we;
    logic [DW-1:0]        mem_rdata;
    logic [2:0]           grant_id;
    logic                 busy;

    modport slave (
        input  c_rd, c_wr, c_addr, c_wdata, mem_rdata,
        output c_rdata, c_dacq, mem_addr, mem_wdata, mem_we, grant_id, busy
    );

    modport master (
        output c_rd, c_wr, c_addr, c_wdata, mem_rdata,
        input  c_rdata, c_dacq, mem_addr, mem_wdata, mem_we, grant_id, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM among NCORES cores.
// One transaction in flight; registered read data and a one-cycle ack pulse.
module dmem_arbiter #(
    parameter int NCORES = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic            CLK,
    input  logic            RST,
    dmem_arbiter_if.slave   bus
);
    localparam int unsigned NC = NCORES;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_rr_ptr;
    logic [2:0]        r_grant;
    logic [NCORES-1:0] r_mask;
    logic              r_op_wr;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_rdata;

    logic [NCORES-1:0] w_req;
    logic [NCORES-1:0] w_onehot;
    logic [NCORES-1:0] w_psel;
    logic [2:0]        w_idx;
    logic [2:0]        w_pick;
    logic              w_found;
    logic              w_sel_wr;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;

    assign w_req    = (bus.c_rd | bus.c_wr) & ~r_mask;
    assign w_onehot = NCORES'(1) << r_grant;

    // Search starts one past the last served core so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NC; i++) begin
            w_idx = 3'((32'(r_rr_ptr) + i) % NC);
            if (!w_found && (|(w_req & (NCORES'(1) << w_idx)))) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_psel      = NCORES'(1) << w_pick;
    assign w_sel_wr    = |(bus.c_wr & w_psel);
    assign w_sel_addr  = AW'(bus.c_addr >> (32'(w_pick) * 32'(AW)));
    assign w_sel_wdata = DW'(bus.c_wdata >> (32'(w_pick) * 32'(DW)));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = ISSUE;
            ISSUE:   w_next = r_op_wr ? ACK : RDWAIT;
            RDWAIT:  w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_rr_ptr <= 3'(NCORES - 1);
            r_grant  <= '0;
            r_mask   <= '0;
            r_op_wr  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            // Served core sits out exactly one IDLE cycle so its stale request is not re-granted.
            r_mask  <= (r_state == ACK) ? w_onehot : '0;
            if (r_state == IDLE && w_found) begin
                r_rr_ptr <= w_pick;
                r_grant  <= w_pick;
                r_op_wr  <= w_sel_wr;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
            end
            if (r_state == RDWAIT) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = (r_state == ISSUE) && r_op_wr;
    assign bus.c_rdata   = r_rdata;
    assign bus.c_dacq    = (r_state == ACK) ? w_onehot : '0;
    assign bus.grant_id  = r_grant;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected acks and RAM writes are queued at issue
// time and popped by an independent negedge monitor.
module tb_dmem_arbiter;
    localparam int NC = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct { int core; logic [7:0] rdata; } ack_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dmem_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus();

    dmem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Synchronous single-port RAM with a preload port used during reset.
    logic [7:0] ram [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;
    always @(posedge CLK) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int   n_vec = 0;
    int   n_err = 0;
    ack_t sb_ack[$];
    wr_t  sb_wr[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    ack_t ea;
    wr_t  ew;
    always @(negedge CLK) begin
        if (!RST && bus.c_dacq != '0) begin
            if (sb_ack.size() == 0) begin
                chk("unexpected_ack", 32'(bus.c_dacq), 32'd0);
            end else begin
                ea = sb_ack.pop_front();
                chk("ack_onehot", 32'(bus.c_dacq), 32'(1) << ea.core);
                chk("ack_rdata", 32'(bus.c_rdata), 32'(ea.rdata));
                chk("ack_grant_id", 32'(bus.grant_id), 32'(ea.core));
            end
        end
        if (!RST && bus.mem_we) begin
            if (sb_wr.size() == 0) begin
                chk("unexpected_we", 32'(bus.mem_we), 32'd0);
            end else begin
                ew = sb_wr.pop_front();
                chk("we_addr", 32'(bus.mem_addr), 32'(ew.addr));
                chk("we_data", 32'(bus.mem_wdata), 32'(ew.data));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.c_rd = '0;
        bus.c_wr = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic req(input int core, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
        bus.c_rd[core] = rd;
        bus.c_wr[core] = wr;
        bus.c_addr[core*AW +: AW]  = a;
        bus.c_wdata[core*DW +: DW] = d;
    endtask

    task automatic release_core(input int core);
        if (core >= 0) begin
            bus.c_rd[core] = 1'b0;
            bus.c_wr[core] = 1'b0;
        end
    endtask

    task automatic wait_ack(output int core, input int budget);
        core = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (bus.c_dacq != '0) begin
                core = bus.c_dacq[1] ? 1 : 0;
                break;
            end
        end
        if (core < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: no c_dacq within %0d cycles at %0t", budget, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        RST = 1'b1;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        bus.c_rd = '0; bus.c_wr = '0; bus.c_addr = '0; bus.c_wdata = '0;
        tick();
        preload(8'h10, 8'hA5);
        preload(8'h30, 8'h11);
        preload(8'h31, 8'h22);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_dacq", 32'(bus.c_dacq), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        chk("rst_rdata", 32'(bus.c_rdata), 32'd0);
        RST = 1'b0;

        // T1 single read, core 0
        req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        sb_ack.push_back('{core: 0, rdata: 8'hA5});
        tick();
        chk("t1_addr", 32'(bus.mem_addr), 32'h10);
        chk("t1_busy_issue", 32'(bus.busy), 32'd1);
        chk("t1_no_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("t1_busy_rdwait", 32'(bus.busy), 32'd1);
        chk("t1_no_early_ack", 32'(bus.c_dacq), 32'd0);
        tick();
        chk("t1_dacq", 32'(bus.c_dacq), 32'd1);
        release_core(0);
        tick();
        chk("t1_idle", 32'(bus.busy), 32'd0);

        // T2 single write, core 1, then read-back by core 0
        req(1, 1'b0, 1'b1, 8'h20, 8'h3C);
        sb_wr.push_back('{addr: 8'h20, data: 8'h3C});
        sb_ack.push_back('{core: 1, rdata: 8'hA5});
        tick();
        chk("t2_we", 32'(bus.mem_we), 32'd1);
        chk("t2_addr", 32'(bus.mem_addr), 32'h20);
        chk("t2_wdata", 32'(bus.mem_wdata), 32'h3C);
        tick();
        chk("t2_we_once", 32'(bus.mem_we), 32'd0);
        chk("t2_dacq", 32'(bus.c_dacq), 32'd2);
        release_core(1);
        tick();
        req(0, 1'b1, 1'b0, 8'h20, 8'h00);
        sb_ack.push_back('{core: 0, rdata: 8'h3C});
        wait_ack(c, 10);
        chk("t2_rb_core", 32'(c), 32'd0);
        release_core(c);
        tick();

        // T3 simultaneous reads from reset
        do_reset();
        req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        req(1, 1'b1, 1'b0, 8'h31, 8'h00);
        sb_ack.push_back('{core: 0, rdata: 8'h11});
        sb_ack.push_back('{core: 1, rdata: 8'h22});
        wait_ack(c, 10);
        chk("t3_first", 32'(c), 32'd0);
        release_core(c);
        wait_ack(c, 10);
        chk("t3_second", 32'(c), 32'd1);
        release_core(c);
        tick();

        // T4 fairness: both cores hold write requests for 8 transactions
        do_reset();
        req(0, 1'b0, 1'b1, 8'h40, 8'hC0);
        req(1, 1'b0, 1'b1, 8'h41, 8'hC1);
        for (int i = 0; i < 8; i++) begin
            sb_ack.push_back('{core: i % 2, rdata: 8'h00});
            sb_wr.push_back((i % 2) == 0 ? '{addr: 8'h40, data: 8'hC0} : '{addr: 8'h41, data: 8'hC1});
        end
        for (int i = 0; i < 8; i++) begin
            wait_ack(c, 10);
            chk("t4_order", 32'(c), 32'(i % 2));
        end
        release_core(0);
        release_core(1);
        tick();

        // T4 lone core re-requesting immediately sits out one masked IDLE cycle
        req(0, 1'b0, 1'b1, 8'h42, 8'h5A);
        for (int i = 0; i < 2; i++) begin
            sb_ack.push_back('{core: 0, rdata: 8'h00});
            sb_wr.push_back('{addr: 8'h42, data: 8'h5A});
        end
        wait_ack(c, 10);
        chk("t4_lone_first", 32'(c), 32'd0);
        tick();
        chk("t4_mask_idle", 32'(bus.busy), 32'd0);
        tick();
        chk("t4_grant_idle", 32'(bus.busy), 32'd0);
        tick();
        chk("t4_lone_we", 32'(bus.mem_we), 32'd1);
        tick();
        chk("t4_lone_ack", 32'(bus.c_dacq), 32'd1);
        release_core(0);
        tick();

        // Load a nonzero c_rdata so the mid-read reset is observable
        req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        sb_ack.push_back('{core: 0, rdata: 8'h11});
        wait_ack(c, 10);
        release_core(c);
        tick();

        // T5 reset during RDWAIT of a core-1 read
        req(1, 1'b1, 1'b0, 8'h31, 8'h00);
        tick();
        chk("t5_busy_issue", 32'(bus.busy), 32'd1);
        tick();
        chk("t5_addr", 32'(bus.mem_addr), 32'h31);
        RST = 1'b1;
        release_core(1);
        tick();
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_dacq", 32'(bus.c_dacq), 32'd0);
        chk("t5_rdata", 32'(bus.c_rdata), 32'd0);
        chk("t5_we", 32'(bus.mem_we), 32'd0);
        RST = 1'b0;
        tick();
        tick();
        chk("t5_no_late_ack", 32'(bus.c_dacq), 32'd0);
        req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        sb_ack.push_back('{core: 0, rdata: 8'hA5});
        wait_ack(c, 10);
        chk("t5_after_core", 32'(c), 32'd0);
        release_core(c);
        tick();

        // T6 rd+wr on one core is a write; c_rdata stays at the last read value
        req(0, 1'b1, 1'b1, 8'h05, 8'h77);
        sb_wr.push_back('{addr: 8'h05, data: 8'h77});
        sb_ack.push_back('{core: 0, rdata: 8'hA5});
        wait_ack(c, 10);
        chk("t6_core", 32'(c), 32'd0);
        release_core(c);
        tick();
        tick();
        chk("t6_single_ack", 32'(bus.c_dacq), 32'd0);
        req(1, 1'b1, 1'b0, 8'h05, 8'h00);
        sb_ack.push_back('{core: 1, rdata: 8'h77});
        wait_ack(c, 10);
        chk("t6_rb_core", 32'(c), 32'd1);
        release_core(c);
        tick();
        tick();

        chk("sb_ack_drained", 32'(sb_ack.size()), 32'd0);
        chk("sb_wr_drained", 32'(sb_wr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
